// File: rtl/noc_pkg.sv
// Shared NoC definitions: default flit width, default buffer depth and flit type.
package noc_pkg;

  localparam int FLIT_WIDTH = 32;
  localparam int BUF_DEPTH  = 4;

  typedef logic [FLIT_WIDTH-1:0] flit_t;

endpackage

// File: rtl/buffer_mem.sv
// Flit register file: one synchronous write port, one asynchronous read port.
// Storage is intentionally not reset; the owner tracks which slots are valid.
module buffer_mem #(
  parameter int WIDTH = noc_pkg::FLIT_WIDTH,
  parameter int DEPTH = noc_pkg::BUF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Capture the incoming flit into its slot on a write
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/input_buffer.sv
// Router input-port flit FIFO with first-word-fall-through head, full
// back-pressure (ret) and a sticky overflow flag for flits dropped while full.
module input_buffer #(
  parameter int FLIT_WIDTH = noc_pkg::FLIT_WIDTH,
  parameter int DEPTH      = noc_pkg::BUF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       val,
  input  logic [FLIT_WIDTH-1:0]      data_in,
  output logic                       ret,
  output logic                       out_valid,
  output logic [FLIT_WIDTH-1:0]      out_data,
  input  logic                       out_ack,
  output logic                       ovf,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;

  // Flags decode straight from the count register so upstream sees no logic
  // depth beyond a compare; a val while full is therefore always an overflow.
  assign w_full    = (r_cnt == CW'(DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_push    = val & ~w_full;
  assign w_pop     = out_ack & ~w_empty;

  assign ret       = w_full;
  assign out_valid = ~w_empty;
  assign count     = r_cnt;
  assign ovf       = r_ovf;

  buffer_mem #(
    .WIDTH (FLIT_WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wrPtr),
    .i_wdata (data_in),
    .i_raddr (r_rdPtr),
    .o_rdata (out_data)
  );

  // Pointers wrap naturally at DEPTH, which is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Occupancy moves only when exactly one of push/pop happens
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_push && !w_pop) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (w_pop && !w_push) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Overflow latches on any flit offered while full and holds until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (val && w_full) begin
      r_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_input_buffer.sv
// Self-checking bench for input_buffer: directed scenarios followed by random
// traffic, all compared against a queue-based model of the FIFO.
module tb_input_buffer;
  import noc_pkg::*;

  localparam int DEPTH = BUF_DEPTH;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk;
  logic          rst_n;
  logic          val;
  flit_t         data_in;
  logic          ret;
  logic          out_valid;
  flit_t         out_data;
  logic          out_ack;
  logic          ovf;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  flit_t modelQ[$];
  bit    modelOvf;

  input_buffer #(
    .FLIT_WIDTH (FLIT_WIDTH),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .val       (val),
    .data_in   (data_in),
    .ret       (ret),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ack   (out_ack),
    .ovf       (ovf),
    .count     (count)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Compare every DUT output against what the model queue implies
  task automatic checkModel(input string tag);
    checkOutput({tag, ".count"}, 32'(count), 32'(modelQ.size()));
    checkOutput({tag, ".ret"}, 32'(ret), 32'(modelQ.size() == DEPTH));
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(modelQ.size() != 0));
    checkOutput({tag, ".ovf"}, 32'(ovf), 32'(modelOvf));
    if (modelQ.size() != 0) begin
      checkOutput({tag, ".out_data"}, out_data, modelQ[0]);
    end
  endtask

  // Drive one cycle of inputs, advance the model by the FIFO's rules, then
  // sample just after the rising edge.
  task automatic applyStimulus(input bit v, input flit_t d, input bit a);
    bit doPush;
    bit doPop;
    @(negedge clk);
    val     = v;
    data_in = d;
    out_ack = a;
    doPush  = v && (modelQ.size() < DEPTH);
    doPop   = a && (modelQ.size() > 0);
    if (v && modelQ.size() == DEPTH) modelOvf = 1'b1;
    @(posedge clk);
    #1;
    if (doPop)  void'(modelQ.pop_front());
    if (doPush) modelQ.push_back(d);
  endtask

  initial begin
    flit_t expSeq[4];
    rst_n   = 1'b0;
    val     = 1'b0;
    data_in = '0;
    out_ack = 1'b0;
    modelOvf = 1'b0;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, '0, 0);
    checkModel("reset_idle");

    // Fill with four flits
    expSeq[0] = 32'hA1; expSeq[1] = 32'hB2; expSeq[2] = 32'hC3; expSeq[3] = 32'hD4;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, expSeq[i], 0);
      checkModel("fill");
    end
    checkOutput("fill.full_ret", 32'(ret), 32'd1);
    checkOutput("fill.full_count", 32'(count), 32'd4);

    // Full: offer 0xEE with a pop in the same cycle
    applyStimulus(1, 32'hEE, 1);
    checkModel("full_push_pop");
    checkOutput("full_push_pop.head", out_data, 32'hB2);
    checkOutput("full_push_pop.ovf", 32'(ovf), 32'd1);
    checkOutput("full_push_pop.ret_drop", 32'(ret), 32'd0);

    // Drain the rest in order
    for (int i = 1; i < 4; i++) begin
      checkOutput("drain.order", out_data, expSeq[i]);
      applyStimulus(0, '0, 1);
      checkModel("drain");
    end

    // Empty: ack alone does nothing
    applyStimulus(0, 32'h77, 1);
    checkModel("empty_ack");
    checkOutput("empty_ack.count", 32'(count), 32'd0);

    // Empty: push and ack together is push only
    applyStimulus(1, 32'h55, 1);
    checkModel("empty_push_ack");
    checkOutput("empty_push_ack.data", out_data, 32'h55);

    // Half full, then sustained push+pop across pointer wrap
    applyStimulus(1, 32'h100, 0);
    checkModel("half");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, flit_t'(32'h200 + i), 1);
      checkModel("stream");
      checkOutput("stream.count", 32'(count), 32'd2);
    end

    // Bring to three entries, then assert reset between clock edges
    while (modelQ.size() < 3) begin
      applyStimulus(1, $urandom, 0);
      checkModel("pre_reset");
    end
    @(negedge clk);
    val = 1'b0;
    out_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelQ.delete();
    modelOvf = 1'b0;
    checkOutput("async_reset.count", 32'(count), 32'd0);
    checkOutput("async_reset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_reset.ret", 32'(ret), 32'd0);
    checkOutput("async_reset.ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic; val is biased high so full and overflow are exercised
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 9) < 4));
      checkModel("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_buffer.md
# input_buffer

Per-port flit FIFO at the receiving side of a router link. It accepts flits pushed by the upstream router's output flow control (`val` plus data). It raises `ret` while it cannot take another flit. It presents the head flit, first-word-fall-through, to the local routing/crossbar stage, which pops it with `out_ack`. One instance sits behind every input port of a router.

## Interface
Parameters:
- `FLIT_WIDTH`, 32, width of one flit in bits
- `DEPTH`, 4, number of flit slots; power of two, ≥ 2

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `val`  in  1  upstream request: a flit is on `data_in` this cycle
- `data_in`  in  FLIT_WIDTH  flit from upstream link
- `ret`  out  1  buffer full; upstream must not assert `val`
- `out_valid`  out  1  head flit present on `out_data`
- `out_data`  out  FLIT_WIDTH  head flit (FWFT)
- `out_ack`  in  1  downstream consumes head flit this cycle
- `ovf`  out  1  sticky: a flit arrived while full and was dropped
- `count`  out  $clog2(DEPTH+1)  current occupancy

## Operation
- State: `wr_ptr` and `rd_ptr` are each $clog2(DEPTH) bits. `cnt` is $clog2(DEPTH+1) bits. A memory holds DEPTH × FLIT_WIDTH. `ovf_r` is 1 bit.
- `ret` = (`cnt` == DEPTH). `out_valid` = (`cnt` != 0). `out_data` = mem[`rd_ptr`]. All three decode directly from registers.
- Push (`push`) = `val` & ~`ret`. Writes `data_in` to mem[`wr_ptr`] and increments `wr_ptr` modulo DEPTH (natural wrap).
- Pop (`pop`) = `out_ack` & `out_valid`. Increments `rd_ptr` modulo DEPTH.
- `cnt` update:
  - push only: +1
  - pop only: −1
  - both or neither: unchanged
- Full and `val`=1: the flit is dropped and `ovf_r` is set. `ovf_r` stays set until reset. This holds even if `out_ack`=1 in the same cycle: no pass-through while full, because `ret` was already high.
- Empty and `out_ack`=1: ignored. There is no pointer or count change.
- Empty and `val`=1 and `out_ack`=1: push only. The flit is not bypassed to the output.
- Memory contents are not reset. `out_data` is don't-care while `out_valid`=0.

## Timing
- Reset (async assert, sync release acceptable): pointers=0, `cnt`=0, `ovf`=0, `ret`=0, `out_valid`=0.
- Write latency: a flit pushed at edge N is visible on `out_data` with `out_valid`=1 immediately after edge N, i.e. in cycle N+1.
- `ret` rises in the cycle after the push that fills the last slot. It falls in the cycle after the first pop from full.
- Upstream sees `ret` combinationally from a register, so there is no extra skid slot. A `val` in the same cycle `ret` is high is an overflow.
- Reset mid-operation: all flits are discarded at once and outputs take their reset values asynchronously.
- Throughput: one push and one pop per cycle sustained when 0 < `cnt` < DEPTH.

## Structure
- Shared package `noc_pkg`:
  - `FLIT_WIDTH` default
  - `BUF_DEPTH` default
  - flit typedef `flit_t`
- Sub-module `buffer_mem`: DEPTH × FLIT_WIDTH register file with one write port and one asynchronous read port. No reset.
- Top level holds pointers, count, flags and the push/pop decode.

## Test plan
- Reset then idle → `ret`=0, `out_valid`=0, `count`=0, `ovf`=0.
- Push 0xA1, 0xB2, 0xC3, 0xD4 on consecutive cycles, DEPTH=4 → `count`=4 and `ret`=1 after the 4th edge. Pops then return A1, B2, C3, D4 in order. `ret` drops after the first pop.
- Full, then `val`=1 with 0xEE and `out_ack`=1 in the same cycle → 0xEE dropped, `ovf`=1, head advances to B2, `count`=3.
- Half full, continuous push and pop for 20 cycles → `count` constant, data order preserved across pointer wrap.
- Empty, `out_ack`=1 alone → no change. Empty, `val`=1 with 0x55 and `out_ack`=1 → `count`=1, `out_data`=0x55 next cycle.
- `rst_n` pulled low with `count`=3 → `count`=0, `out_valid`=0, `ret`=0 immediately, without waiting for a clock edge.
